// File: rtl/vdp_super_res_loader.sv
// Super-high-res pixel loader: packs CPU R,G,B byte writes into 32-bit pixel
// words and hands them to the VRAM write arbiter through a small FIFO and req/ack.
module vdp_super_res_loader #(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        super_high_res,
  input  logic        cpu_wr,
  input  logic        cpu_port,
  input  logic [7:0]  cpu_data,
  output logic        vram_wr_req,
  input  logic        vram_wr_ack,
  output logic [16:0] vram_wr_addr,
  output logic [31:0] vram_wr_data,
  output logic [7:0]  status
);

  // state | meaning
  // IDLE  | no request outstanding; loads FIFO head when one is queued
  // REQ   | vram_wr_req held with stable addr/data until acknowledged
  typedef enum logic {IDLE, REQ} state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [16:0]   ADDR_LIMIT = 17'(2 * WIDTH * HEIGHT);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

  state_t        state;
  logic [16:0]   addr_ptr;
  logic [1:0]    byte_idx;
  logic [1:0]    addr_idx;
  logic [7:0]    r_byte;
  logic [7:0]    g_byte;
  logic          overflow;

  logic [16:0]   fifo_addr [FIFO_DEPTH];
  logic [23:0]   fifo_rgb  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic        wr_en;
  logic        data_wr;
  logic        addr_wr;
  logic        pixel_done;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        push;
  logic        drop;
  logic [16:0] addr_inc;
  logic [16:0] addr_next;

  always_comb begin
    wr_en      = cpu_wr & super_high_res;
    data_wr    = wr_en & ~cpu_port;
    addr_wr    = wr_en & cpu_port;
    pixel_done = data_wr && (byte_idx == 2'd2);
    fifo_full  = (count == DEPTH_C);
    fifo_empty = (count == '0);
    pop        = (state == REQ) && vram_wr_ack;
    // a full FIFO still accepts a pixel when the head leaves in the same cycle
    push       = pixel_done && (!fifo_full || pop);
    drop       = pixel_done && fifo_full && !pop;
    addr_inc   = addr_ptr + 17'd2;
    addr_next  = (addr_inc == ADDR_LIMIT) ? 17'd0 : addr_inc;
  end

  // CPU side: address assembly, byte packing, overflow tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_ptr <= '0;
      byte_idx <= '0;
      addr_idx <= '0;
      r_byte   <= '0;
      g_byte   <= '0;
      overflow <= 1'b0;
    end else if (!super_high_res) begin
      byte_idx <= '0;
      addr_idx <= '0;
    end else if (addr_wr) begin
      byte_idx <= '0;
      overflow <= 1'b0;
      case (addr_idx)
        2'd0: begin
          addr_ptr[7:0] <= {cpu_data[7:1], 1'b0};
          addr_idx      <= 2'd1;
        end
        2'd1: begin
          addr_ptr[15:8] <= cpu_data;
          addr_idx       <= 2'd2;
        end
        default: begin
          addr_ptr[16] <= cpu_data[0];
          addr_idx     <= 2'd0;
        end
      endcase
    end else if (data_wr) begin
      case (byte_idx)
        2'd0: begin
          r_byte   <= cpu_data;
          byte_idx <= 2'd1;
        end
        2'd1: begin
          g_byte   <= cpu_data;
          byte_idx <= 2'd2;
        end
        default: begin
          byte_idx <= 2'd0;
          if (push) addr_ptr <= addr_next;
          if (drop) overflow <= 1'b1;
        end
      endcase
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= addr_ptr;
      fifo_rgb[wr_ptr]  <= {r_byte, g_byte, cpu_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // VRAM write handshake; entry stays in the FIFO until acknowledged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      vram_wr_req  <= 1'b0;
      vram_wr_addr <= '0;
      vram_wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            vram_wr_addr <= fifo_addr[rd_ptr];
            vram_wr_data <= {8'h00, fifo_rgb[rd_ptr]};
            vram_wr_req  <= 1'b1;
            state        <= REQ;
          end
        end
        default: begin
          if (vram_wr_ack) begin
            vram_wr_req <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status <= '0;
    end else begin
      status <= {3'b000, byte_idx, overflow, (!fifo_empty || vram_wr_req), fifo_full};
    end
  end

endmodule

// File: doc/vdp_super_res_loader.md
# vdp_super_res_loader

Upstream feeder for the super-high-res display path: accepts CPU byte writes, packs successive R,G,B bytes into 24-bit pixels, and writes them to VRAM as 32-bit words. Addresses match the display fetch layout (one pixel per word, address step 2, frame origin 0). A small FIFO decouples CPU writes from the VRAM write arbiter through a req/ack handshake.

## Interface
- WIDTH, 64, pixels per super-res line
- HEIGHT, 64, super-res lines per frame
- FIFO_DEPTH, 4, pixel FIFO entries (power of two, ≥2)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- super_high_res  in  1  mode enable; when low, CPU writes are ignored
- cpu_wr  in  1  single-cycle CPU write strobe
- cpu_port  in  1  0 = pixel data byte, 1 = address byte
- cpu_data  in  8  write data
- vram_wr_req  out  1  write request, held until acknowledged
- vram_wr_ack  in  1  single-cycle acknowledge from arbiter
- vram_wr_addr  out  17  write address; bit 0 always 0
- vram_wr_data  out  32  {8'h00, R, G, B}
- status  out  8  {3'b0, byte_idx[1:0], overflow, busy, fifo_full}

## Operation
- Reset values: vram_wr_req=0, vram_wr_addr=0, vram_wr_data=0, status=0. Internal: addr_ptr=0, byte_idx=0, addr_idx=0, FIFO empty, overflow=0.
- Writes on either port are accepted only when cpu_wr=1 and super_high_res=1.
- Address port, addr_idx cycles 0→1→2→0:
  - 0: addr_ptr[7:1] ← cpu_data[7:1]; addr_ptr[0] ← 0.
  - 1: addr_ptr[15:8] ← cpu_data.
  - 2: addr_ptr[16] ← cpu_data[0].
  - Every address write clears byte_idx and overflow.
- Data port, byte_idx cycles 0→1→2→0:
  - 0 latches R; 1 latches G.
  - 2 forms pixel {8'h00, R, G, cpu_data} and pushes (addr_ptr, pixel) into the FIFO.
  - On push, addr_ptr ← addr_ptr + 2 (17-bit). If the result equals 2·WIDTH·HEIGHT (8192 by default), addr_ptr ← 0.
  - Addresses loaded above the limit increment modulo 2^17 without wrap.
- FIFO full at the third byte and no pop in that cycle: pixel dropped, addr_ptr not advanced, overflow set (sticky until next address write). byte_idx still returns to 0.
- Simultaneous push and pop while full: allowed; count unchanged, no overflow.
- Write FSM, two states:
  - IDLE: FIFO non-empty → load head into vram_wr_addr/vram_wr_data, set vram_wr_req, go to REQ.
  - REQ: hold req, addr and data stable. On vram_wr_ack, pop the FIFO, clear req, go to IDLE.
  - req is always low for at least one cycle between transactions.
- vram_wr_ack while in IDLE is ignored.
- super_high_res falling:
  - An in-flight request and all queued entries still complete.
  - byte_idx and addr_idx reset to 0; addr_ptr is kept.
- Status bits: busy = FIFO non-empty or req high; fifo_full = count == FIFO_DEPTH.

## Timing
- All outputs registered.
- Third data byte at edge N → FIFO entry at N → vram_wr_req high after edge N+1 (when idle and the FIFO was empty).
- Ack sampled at edge M → req low after M; next req no earlier than after edge M+1.
- status reflects the FIFO/byte_idx update one cycle after the causing write.
- Reset asserted mid-transaction: req drops immediately (asynchronous), FIFO content discarded; the arbiter must treat a dropped req as aborted.

## Test plan
- Reset, address writes 0x10,0x00,0x00, data 0x11,0x22,0x33 → req high two cycles later with addr=0x00010, data=0x00112233; ack → req low, busy=0.
- Address set to 8190, one pixel, then a second pixel → writes at 8190 then 0 (wrap).
- Arbiter never acks; push 5 pixels with FIFO_DEPTH=4 → fifo_full=1, overflow=1, 5th pixel lost; acks then yield exactly 4 writes at consecutive +2 addresses.
- Third byte coincides with ack while full → no overflow, 5 writes total after draining.
- super_high_res=0 during the data-byte sequence → bytes ignored, byte_idx=0, pending request still completes on ack.
- Assert reset while req high → req=0 that cycle, status=0, no further requests.
